// File: rtl/mem_bank_array_if.sv
// rtl/mem_bank_array_if.sv - request/response bundle for mem_bank_array; rd_parity_err only with MEM_BANK_PARITY_EN
interface mem_bank_array_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                      chip_en;
  logic [ADDR_WIDTH-1:0]     addr;
  logic                      rd_en;
  logic                      wr_en;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [DATA_WIDTH/8-1:0]   wr_be;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      rd_valid;
`ifdef MEM_BANK_PARITY_EN
  logic [DATA_WIDTH/8-1:0]   rd_parity_err;

  modport master (
    output chip_en, addr, rd_en, wr_en, wr_data, wr_be,
    input  ready, rd_data, rd_valid, rd_parity_err
  );
  modport slave (
    input  chip_en, addr, rd_en, wr_en, wr_data, wr_be,
    output ready, rd_data, rd_valid, rd_parity_err
  );
`else
  modport master (
    output chip_en, addr, rd_en, wr_en, wr_data, wr_be,
    input  ready, rd_data, rd_valid
  );
  modport slave (
    input  chip_en, addr, rd_en, wr_en, wr_data, wr_be,
    output ready, rd_data, rd_valid
  );
`endif
endinterface

// File: rtl/mem_bank_array.sv
// rtl/mem_bank_array.sv - banked single-port SRAM wrapper with zeroing sweep; optional byte parity via MEM_BANK_PARITY_EN
module mem_bank_array #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_BANKS  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  mem_bank_array_if.slave   bus
);
  localparam int BANK_SEL_W = $clog2(NUM_BANKS);
  localparam int BANK_AW    = ADDR_WIDTH - BANK_SEL_W;
  localparam int BANK_DEPTH = 1 << BANK_AW;
  localparam int NB         = DATA_WIDTH / 8;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic [BANK_AW-1:0]      init_cnt_q, init_cnt_d;
  logic                    rd_vld_q, rd_vld_d;
  logic [BANK_SEL_W-1:0]   rd_bank_q, rd_bank_d;

  logic                    accept;
  logic                    rd_acc;
  logic [BANK_SEL_W-1:0]   sel_bank;
  logic [BANK_AW-1:0]      row;
  logic [BANK_AW-1:0]      mem_row;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [NUM_BANKS-1:0][NB-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   bank_rdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0]   mux_data;

  assign sel_bank = bus.addr[ADDR_WIDTH-1 -: BANK_SEL_W];
  assign row      = bus.addr[BANK_AW-1:0];
  assign accept   = (state_q == ST_RUN) & bus.chip_en & (bus.rd_en | bus.wr_en);
  assign rd_acc   = accept & bus.rd_en;
  assign bus.ready = (state_q == ST_RUN);

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (&init_cnt_q) state_d = ST_RUN;
    end
  end

  // The sweep owns every bank's write port while INIT; bus writes only in RUN.
  always_comb begin
    mem_row   = row;
    mem_wdata = bus.wr_data;
    mem_be    = '0;
    if (state_q == ST_INIT) begin
      mem_row   = init_cnt_q;
      mem_wdata = '0;
      mem_be    = '1;
    end else if (accept & bus.wr_en) begin
      mem_be[sel_bank] = bus.wr_be;
    end
  end

  always_comb begin
    rd_vld_d  = rd_acc;
    rd_bank_d = rd_acc ? sel_bank : rd_bank_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      rd_vld_q   <= 1'b0;
      rd_bank_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rd_vld_q   <= rd_vld_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

`ifdef MEM_BANK_PARITY_EN
  logic [NB-1:0] mem_wpar;
  logic [NB-1:0] bank_rpar [NUM_BANKS];
  logic [NB-1:0] mux_par;
  logic [NB-1:0] par_err;

  always_comb begin
    mem_wpar = '0;
    for (int k = 0; k < NB; k++) mem_wpar[k] = ^mem_wdata[8*k +: 8];
  end
`endif

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rd_hit;

    assign rd_hit = rd_acc & (sel_bank == BANK_SEL_W'(b));

    // Old contents are captured here, so a same-edge write is read-before-write.
    always_comb begin
      rdata_d = rdata_q;
      if (rd_hit) rdata_d = mem[row];
    end

    always_ff @(posedge clock) begin
      for (int k = 0; k < NB; k++) begin
        if (mem_be[b][k]) mem[mem_row][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) rdata_q <= '0;
      else       rdata_q <= rdata_d;
    end

    assign bank_rdata[b] = rdata_q;

`ifdef MEM_BANK_PARITY_EN
    logic [NB-1:0] par_mem [BANK_DEPTH];
    logic [NB-1:0] rpar_q, rpar_d;

    always_comb begin
      rpar_d = rpar_q;
      if (rd_hit) rpar_d = par_mem[row];
    end

    always_ff @(posedge clock) begin
      for (int k = 0; k < NB; k++) begin
        if (mem_be[b][k]) par_mem[mem_row][k] <= mem_wpar[k];
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) rpar_q <= '0;
      else       rpar_q <= rpar_d;
    end

    assign bank_rpar[b] = rpar_q;
`endif
  end

  assign mux_data = bank_rdata[rd_bank_q];

`ifdef MEM_BANK_PARITY_EN
  assign mux_par = bank_rpar[rd_bank_q];

  always_comb begin
    par_err = '0;
    for (int k = 0; k < NB; k++) par_err[k] = mux_par[k] ^ (^mux_data[8*k +: 8]);
  end
`endif

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_vld_q, out_vld_d;
`ifdef MEM_BANK_PARITY_EN
    logic [NB-1:0]         out_err_q, out_err_d;
`endif

    always_comb begin
      out_vld_d  = rd_vld_q;
      out_data_d = rd_vld_q ? mux_data : out_data_q;
`ifdef MEM_BANK_PARITY_EN
      out_err_d  = rd_vld_q ? par_err : '0;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        out_vld_q  <= 1'b0;
        out_data_q <= '0;
`ifdef MEM_BANK_PARITY_EN
        out_err_q  <= '0;
`endif
      end else begin
        out_vld_q  <= out_vld_d;
        out_data_q <= out_data_d;
`ifdef MEM_BANK_PARITY_EN
        out_err_q  <= out_err_d;
`endif
      end
    end

    assign bus.rd_valid = out_vld_q;
    assign bus.rd_data  = out_data_q;
`ifdef MEM_BANK_PARITY_EN
    assign bus.rd_parity_err = out_err_q;
`endif
  end else begin : g_lat1
    assign bus.rd_valid = rd_vld_q;
    assign bus.rd_data  = mux_data;
`ifdef MEM_BANK_PARITY_EN
    assign bus.rd_parity_err = rd_vld_q ? par_err : '0;
`endif
  end

endmodule

// File: tb/tb_mem_bank_array.sv
// tb/tb_mem_bank_array.sv - directed bench for mem_bank_array, latency-1 and latency-2 instances in lockstep
module tb_mem_bank_array;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  mem_bank_array_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus1 ();
  mem_bank_array_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus2 ();

  assign bus2.chip_en = bus1.chip_en;
  assign bus2.addr    = bus1.addr;
  assign bus2.rd_en   = bus1.rd_en;
  assign bus2.wr_en   = bus1.wr_en;
  assign bus2.wr_data = bus1.wr_data;
  assign bus2.wr_be   = bus1.wr_be;

  mem_bank_array #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_BANKS(4), .RD_LATENCY(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  mem_bank_array #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_BANKS(4), .RD_LATENCY(2)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct {
    logic        ce;
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ce, input logic rd, input logic wr, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    bus1.chip_en = ce;
    bus1.rd_en   = rd;
    bus1.wr_en   = wr;
    bus1.addr    = a;
    bus1.wr_data = d;
    bus1.wr_be   = be;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
  endtask

  task automatic wait_ready(input int start, output int cnt);
    cnt = start;
    while (!bus1.ready && cnt < 2000) begin
      step();
      cnt++;
    end
  endtask

  task automatic read_both(input string name, input logic [11:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b1, 1'b0, a, 32'h0, 4'h0);
    step();
    idle();
    chk({name, "_v1"}, {31'b0, bus1.rd_valid}, 32'd1);
    chk({name, "_d1"}, bus1.rd_data, exp);
    chk({name, "_v2early"}, {31'b0, bus2.rd_valid}, 32'd0);
    step();
    chk({name, "_v2"}, {31'b0, bus2.rd_valid}, 32'd1);
    chk({name, "_d2"}, bus2.rd_data, exp);
  endtask

  initial begin
    int cnt;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 12'h000, 32'h0,          4'hF, 1'b1, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 12'h3FF, 32'h0,          4'hF, 1'b1, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 12'hC00, 32'h0,          4'hF, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 12'hFFF, 32'h0,          4'hF, 1'b1, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 12'h005, 32'hA5A5_0001, 4'hF, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 12'hC05, 32'h1234_5678, 4'hF, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 12'h010, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 12'h010, 32'h0000_0000, 4'h5, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 12'h010, 32'h0,          4'h0, 1'b1, 32'hFF00_FF00};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 12'h020, 32'h1111_1111, 4'hF, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 12'h030, 32'hDEAD_BEEF, 4'h0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 12'h030, 32'h0,          4'h0, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 12'h040, 32'h5555_5555, 4'hF, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 12'h040, 32'h0,          4'h0, 1'b1, 32'h0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 12'h005, 32'h0,          4'h0, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 12'h405, 32'h0,          4'h0, 1'b1, 32'h0};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 12'h850, 32'hAABB_CCDD, 4'h8, 1'b0, 32'h0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 12'h850, 32'h0,          4'h0, 1'b1, 32'hAA00_0000};

    idle();
    #2;
    chk("rst_ready1", {31'b0, bus1.ready}, 32'd0);
    chk("rst_valid1", {31'b0, bus1.rd_valid}, 32'd0);
    chk("rst_data1", bus1.rd_data, 32'h0);
    chk("rst_ready2", {31'b0, bus2.ready}, 32'd0);
    chk("rst_valid2", {31'b0, bus2.rd_valid}, 32'd0);
    chk("rst_data2", bus2.rd_data, 32'h0);

    step();
    step();
    reset = 1'b0;
    wait_ready(0, cnt);
    chk("init_cycles", cnt, 32'd1024);
    chk("init_ready2", {31'b0, bus2.ready}, 32'd1);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].ce, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      step();
      idle();
      chk($sformatf("vec%0d_v1", i), {31'b0, bus1.rd_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_d1", i), bus1.rd_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_v2early", i), {31'b0, bus2.rd_valid}, 32'd0);
      step();
      chk($sformatf("vec%0d_v2", i), {31'b0, bus2.rd_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_d2", i), bus2.rd_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_v1late", i), {31'b0, bus1.rd_valid}, 32'd0);
    end

    // Back-to-back reads across banks 0 and 3.
    drive(1'b1, 1'b1, 1'b0, 12'h005, 32'h0, 4'h0);
    step();
    drive(1'b1, 1'b1, 1'b0, 12'hC05, 32'h0, 4'h0);
    chk("b2b_v1a", {31'b0, bus1.rd_valid}, 32'd1);
    chk("b2b_d1a", bus1.rd_data, 32'hA5A5_0001);
    chk("b2b_v2idle", {31'b0, bus2.rd_valid}, 32'd0);
    step();
    idle();
    chk("b2b_v1b", {31'b0, bus1.rd_valid}, 32'd1);
    chk("b2b_d1b", bus1.rd_data, 32'h1234_5678);
    chk("b2b_v2a", {31'b0, bus2.rd_valid}, 32'd1);
    chk("b2b_d2a", bus2.rd_data, 32'hA5A5_0001);
    step();
    chk("b2b_v1end", {31'b0, bus1.rd_valid}, 32'd0);
    chk("b2b_v2b", {31'b0, bus2.rd_valid}, 32'd1);
    chk("b2b_d2b", bus2.rd_data, 32'h1234_5678);
    step();
    chk("b2b_v2end", {31'b0, bus2.rd_valid}, 32'd0);

    // Same-cycle read and write: old data returned, new data stored.
    drive(1'b1, 1'b1, 1'b1, 12'h020, 32'h2222_2222, 4'hF);
    step();
    idle();
    chk("col_v1", {31'b0, bus1.rd_valid}, 32'd1);
    chk("col_d1", bus1.rd_data, 32'h1111_1111);
    step();
    chk("col_v2", {31'b0, bus2.rd_valid}, 32'd1);
    chk("col_d2", bus2.rd_data, 32'h1111_1111);
    read_both("col_after", 12'h020, 32'h2222_2222);

    // Reset right after a read is accepted: in-flight result dropped, sweep reruns.
    drive(1'b1, 1'b1, 1'b0, 12'h005, 32'h0, 4'h0);
    step();
    idle();
    reset = 1'b1;
    #1;
    chk("mid_rst_v1", {31'b0, bus1.rd_valid}, 32'd0);
    chk("mid_rst_d1", bus1.rd_data, 32'h0);
    chk("mid_rst_ready", {31'b0, bus1.ready}, 32'd0);
    chk("mid_rst_v2", {31'b0, bus2.rd_valid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("rst_hold%0d_v2", i), {31'b0, bus2.rd_valid}, 32'd0);
    end
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 12'h3FF, 32'hFFFF_FFFF, 4'hF);
      step();
      cnt++;
      chk($sformatf("init_ign%0d_v1", i), {31'b0, bus1.rd_valid}, 32'd0);
      chk($sformatf("init_ign%0d_rdy", i), {31'b0, bus1.ready}, 32'd0);
    end
    idle();
    wait_ready(cnt, cnt);
    chk("reinit_cycles", cnt, 32'd1024);
    read_both("reinit_005", 12'h005, 32'h0);
    read_both("reinit_3ff", 12'h3FF, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bank_array.md
Name: mem_bank_array

Overview:
- Parametrised banked single-port SRAM wrapper; successor to the fixed 4-bank 32x4096 memory wrapper.
- Address MSBs select one of NUM_BANKS banks; LSBs index within the bank.
- Adds:
  - Registered, bank-tracked read path with rd_valid.
  - Configurable read latency.
  - Per-byte write enables.
  - Post-reset zero-initialisation sweep gated by a ready output.
- Sits between bus-side controllers and macro/behavioural storage in the demo chip memory subsystem.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 12: word address width.
- NUM_BANKS, 4: bank count; power of 2, at least 2.
- RD_LATENCY, 1: cycles from accepted read to rd_valid; legal values 1 or 2.
- Derived:
  - BANK_SEL_W = log2(NUM_BANKS).
  - BANK_AW = ADDR_WIDTH - BANK_SEL_W.
  - BANK_DEPTH = 2^BANK_AW.

Ports:
- clock, input, 1: sole clock; all state on rising edge.
- reset, input, 1: asynchronous, active-high reset.
- chip_en, input, 1: request qualifier; no access when low.
- addr, input, ADDR_WIDTH: word address; addr[ADDR_WIDTH-1 -: BANK_SEL_W] = bank, low BANK_AW bits = row.
- rd_en, input, 1: read request.
- wr_en, input, 1: write request.
- wr_data, input, DATA_WIDTH: write data.
- wr_be, input, DATA_WIDTH/8: byte write enables; bit k covers wr_data[8k+7:8k].
- ready, output, 1: high when requests are accepted.
- rd_data, output, DATA_WIDTH: read data; valid only while rd_valid is high.
- rd_valid, output, 1: one-cycle pulse per accepted read.

Behaviour:
- Reset (asynchronous):
  - FSM goes to INIT; init row counter = 0.
  - ready = 0, rd_valid = 0, rd_data = 0.
  - Read pipeline and registered bank index cleared.
- FSM states:
  - INIT: each cycle, write zero to row init_cnt in all banks in parallel (all bytes); init_cnt increments.
  - INIT -> RUN on the cycle init_cnt == BANK_DEPTH-1 is written. INIT lasts exactly BANK_DEPTH cycles after reset deasserts.
  - RUN: ready = 1. RUN is left only via reset.
- Reset asserted mid-INIT or mid-RUN:
  - Restarts INIT from row 0 and drops any in-flight read (no rd_valid).
  - Memory contents are re-zeroed by the sweep.
- Accepted access: ready & chip_en & (rd_en | wr_en). In INIT, requests are ignored with no side effects.
- Bank decode:
  - Exactly one bank enabled per accepted access.
  - Bank index for reads is registered with the request; the output mux uses the registered index, never the live addr.
- Write:
  - Bytes with wr_be[k] = 1 are updated at the clock edge of acceptance.
  - wr_be = 0 performs no write.
- Read:
  - Storage read is synchronous.
  - RD_LATENCY = 1: rd_data/rd_valid are valid the cycle after acceptance.
  - RD_LATENCY = 2: an extra output register is added; valid two cycles after acceptance.
  - Back-to-back reads are fully pipelined, one result per cycle, in order.
- Simultaneous rd_en & wr_en on the same cycle (same address):
  - Write is performed.
  - Read returns the pre-write contents (read-before-write).
  - rd_valid still pulses.
- rd_data holds its last value when rd_valid = 0. Checkers must not sample it then.
- Address wrap: no wrap logic; the full ADDR_WIDTH range maps uniquely.

Optional Feature:
- Macro: MEM_BANK_PARITY_EN.
- When defined:
  - Each byte stores an extra even-parity bit, written with the data byte.
  - The INIT sweep writes parity 0.
  - Added output port rd_parity_err, width DATA_WIDTH/8, aligned with rd_valid. Bit k = 1 when stored byte k's parity mismatches on read; 0 otherwise and at reset.
- When undefined: no parity storage and no rd_parity_err port.

Test Plan:
- Init sweep: NUM_BANKS=4, ADDR_WIDTH=12.
  - Deassert reset -> ready rises exactly 1024 cycles later.
  - Read addr 0x000, 0x3FF, 0xC00, 0xFFF -> rd_data = 0 each.
- Bank isolation: write 0xA5A5_0001 to 0x005 and 0x1234_5678 to 0xC05.
  - Read 0x005 then 0xC05 back-to-back -> rd_valid on two consecutive cycles.
  - rd_data = 0xA5A5_0001 then 0x1234_5678.
- Byte enables: write 0xFFFF_FFFF to 0x010, then 0x0000_0000 with wr_be = 4'b0101.
  - Read 0x010 -> 0xFF00_FF00.
- Latency: RD_LATENCY = 2 build, read 0x005 -> rd_valid exactly 2 cycles after acceptance, rd_data = 0xA5A5_0001.
- Read/write collision: 0x020 holds 0x1111_1111; same-cycle rd_en + wr_en with 0x2222_2222.
  - rd_data = 0x1111_1111.
  - A subsequent read returns 0x2222_2222.
- Reset mid-read / parity:
  - Assert reset the cycle after a read is accepted -> no rd_valid, ready = 0, re-init runs.
  - MEM_BANK_PARITY_EN build: force a storage bit flip in byte 2 -> rd_parity_err = 4'b0100.
